collision_multi: RTL and testbench

- Successor to the single-apple head collision checker in the snake datapath.
- Checks the snake head cell against N_TGT independently enabled target cells (apples or bonuses) and against the playfield boundary.
- Emits registered, edge-detected one-cycle event pulses, with the hit index and mask, a wall event, and a saturating eat counter.
- Sits between the snake/apple position registers and the game-control FSM, in the clk_pix domain.

---
 rtl/collision_multi.sv | 111 +++++++++++
 tb/tb_collision_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/collision_multi.sv
// Snake head collision checker: head cell vs N_TGT enabled target cells and the
// playfield boundary, producing registered rising-edge event pulses and an eat counter.
module collision_multi #(
    parameter int CELL      = 10,
    parameter int N_TGT     = 4,
    parameter int X_MAX     = 640,
    parameter int Y_MAX     = 480,
    parameter int ARM_TICKS = 1,
    localparam int IDX_W    = (N_TGT <= 1) ? 1 : $clog2(N_TGT)
) (
    input  logic                 clk_pix,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [9:0]           head_x,
    input  logic [8:0]           head_y,
    input  logic [10*N_TGT-1:0]  tgt_x,
    input  logic [9*N_TGT-1:0]   tgt_y,
    input  logic [N_TGT-1:0]     tgt_en,
    output logic                 eat_evt,
    output logic [IDX_W-1:0]     eat_idx,
    output logic [N_TGT-1:0]     eat_mask,
    output logic                 wall_evt,
    output logic [7:0]           eat_count,
    output logic                 armed
);

    localparam int ARM_W = (ARM_TICKS < 1) ? 1 : $clog2(ARM_TICKS + 1);
    localparam logic [ARM_W-1:0] ARM_LIM = ARM_W'(ARM_TICKS);
    localparam logic [10:0] CELL11 = 11'(CELL);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);

    logic [ARM_W-1:0] r_arm_cnt;
    logic [N_TGT-1:0] r_hist;
    logic             r_wall_hist;
    logic             r_eat_evt;
    logic             r_wall_evt;
    logic [IDX_W-1:0] r_eat_idx;
    logic [N_TGT-1:0] r_eat_mask;
    logic [7:0]       r_eat_count;

    logic [10:0]      w_hx;
    logic [10:0]      w_hy;
    logic [N_TGT-1:0] w_hit;
    logic [N_TGT-1:0] w_rise;
    logic             w_out;
    logic             w_rise_w;
    logic             w_armed;
    logic [IDX_W-1:0] w_idx;

    // 11-bit zero-extended geometry so x+CELL / y+CELL can never wrap
    assign w_hx = {1'b0, head_x};
    assign w_hy = {2'b00, head_y};

    genvar g;
    for (g = 0; g < N_TGT; g++) begin : g_tgt
        logic [10:0] w_tx;
        logic [10:0] w_ty;
        assign w_tx     = {1'b0, tgt_x[10*g +: 10]};
        assign w_ty     = {2'b00, tgt_y[9*g +: 9]};
        assign w_hit[g] = tgt_en[g]
                          && (w_hx < w_tx + CELL11) && (w_hx + CELL11 > w_tx)
                          && (w_hy < w_ty + CELL11) && (w_hy + CELL11 > w_ty);
    end

    assign w_out    = (w_hx + CELL11 > XMAX11) || (w_hy + CELL11 > YMAX11);
    assign w_rise   = w_hit & ~r_hist;
    assign w_rise_w = w_out & ~r_wall_hist;
    assign w_armed  = (r_arm_cnt == ARM_LIM);

    // Lowest rising channel wins: scan downward so the last assignment is the smallest index
    always_comb begin
        w_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (w_rise[i]) w_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            r_arm_cnt   <= '0;
            r_hist      <= '0;
            r_wall_hist <= 1'b0;
            r_eat_evt   <= 1'b0;
            r_wall_evt  <= 1'b0;
            r_eat_idx   <= '0;
            r_eat_mask  <= '0;
            r_eat_count <= '0;
        end else begin
            if (tick && (r_arm_cnt < ARM_LIM)) r_arm_cnt <= r_arm_cnt + 1'b1;
            // History tracks conditions even while disarmed, so pre-existing overlaps never fire
            r_hist      <= w_hit;
            r_wall_hist <= w_out;
            r_eat_evt   <= w_armed & (|w_rise);
            r_wall_evt  <= w_armed & w_rise_w;
            if (w_armed && (|w_rise)) begin
                r_eat_mask <= w_rise;
                r_eat_idx  <= w_idx;
                if (r_eat_count != 8'hFF) r_eat_count <= r_eat_count + 8'd1;
            end
        end
    end

    assign eat_evt   = r_eat_evt;
    assign wall_evt  = r_wall_evt;
    assign eat_idx   = r_eat_idx;
    assign eat_mask  = r_eat_mask;
    assign eat_count = r_eat_count;
    assign armed     = w_armed;

endmodule

// File: tb/tb_collision_multi.sv
// Directed bench for collision_multi with default parameters (CELL=10, N_TGT=4, ARM_TICKS=1).
module tb_collision_multi;

    logic        clk_pix = 1'b0;
    logic        reset;
    logic        tick;
    logic [9:0]  head_x;
    logic [8:0]  head_y;
    logic [39:0] tgt_x;
    logic [35:0] tgt_y;
    logic [3:0]  tgt_en;
    logic        eat_evt;
    logic [1:0]  eat_idx;
    logic [3:0]  eat_mask;
    logic        wall_evt;
    logic [7:0]  eat_count;
    logic        armed;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses;

    collision_multi dut (
        .clk_pix   (clk_pix),
        .reset     (reset),
        .tick      (tick),
        .head_x    (head_x),
        .head_y    (head_y),
        .tgt_x     (tgt_x),
        .tgt_y     (tgt_y),
        .tgt_en    (tgt_en),
        .eat_evt   (eat_evt),
        .eat_idx   (eat_idx),
        .eat_mask  (eat_mask),
        .wall_evt  (wall_evt),
        .eat_count (eat_count),
        .armed     (armed)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic set_tgt(input int ch, input int x, input int y);
        tgt_x[10*ch +: 10] = 10'(x);
        tgt_y[9*ch +: 9]   = 9'(y);
    endtask

    task automatic set_head(input int x, input int y);
        head_x = 10'(x);
        head_y = 9'(y);
    endtask

    initial begin
        reset  = 1'b1;
        tick   = 1'b0;
        tgt_x  = '0;
        tgt_y  = '0;
        tgt_en = 4'b0000;
        set_head(100, 100);
        set_tgt(0, 100, 100);
        set_tgt(1, 500, 400);
        set_tgt(2, 500, 400);
        set_tgt(3, 500, 400);
        tgt_en = 4'b0001;
        step();
        step();
        check("rst_eat_evt", 32'(eat_evt), 0);
        check("rst_wall_evt", 32'(wall_evt), 0);
        check("rst_count", 32'(eat_count), 0);
        check("rst_mask", 32'(eat_mask), 0);
        check("rst_idx", 32'(eat_idx), 0);
        check("rst_armed", 32'(armed), 0);

        // Disarmed overlap never fires, and is absorbed into history
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(eat_evt);
        end
        check("unarmed_pulses", 32'(pulses), 0);

        tick = 1'b1;
        step();
        tick = 1'b0;
        check("armed_after_tick", 32'(armed), 1);
        step();
        check("preexisting_no_evt", 32'(eat_evt), 0);

        set_head(200, 100);
        step();
        set_head(100, 100);
        step();
        check("t1_evt", 32'(eat_evt), 1);
        check("t1_idx", 32'(eat_idx), 0);
        check("t1_mask", 32'(eat_mask), 4'b0001);
        check("t1_count", 32'(eat_count), 1);
        step();
        check("t1_single_pulse", 32'(eat_evt), 0);
        check("t1_mask_held", 32'(eat_mask), 4'b0001);

        // Edge touching is not a hit; one pixel of overlap is
        set_head(400, 300);
        set_tgt(0, 60, 50);
        set_tgt(1, 59, 50);
        tgt_en = 4'b0011;
        step();
        set_head(50, 50);
        step();
        check("t2_evt", 32'(eat_evt), 1);
        check("t2_idx", 32'(eat_idx), 1);
        check("t2_mask", 32'(eat_mask), 4'b0010);
        check("t2_count", 32'(eat_count), 2);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            pulses += int'(eat_evt);
        end
        check("t2_held_pulses", 32'(pulses), 0);

        // Two targets rising together
        set_head(400, 300);
        set_tgt(1, 300, 200);
        set_tgt(3, 300, 200);
        tgt_en = 4'b1010;
        step();
        set_head(300, 200);
        step();
        check("t3_evt", 32'(eat_evt), 1);
        check("t3_idx", 32'(eat_idx), 1);
        check("t3_mask", 32'(eat_mask), 4'b1010);
        check("t3_count", 32'(eat_count), 3);
        // Target moving while still overlapping gives no new event
        set_tgt(1, 305, 203);
        step();
        step();
        check("t3_move_no_evt", 32'(eat_evt), 0);

        // Wall: 631+10 > 640
        tgt_en = 4'b0000;
        set_head(631, 100);
        step();
        check("t4_wall_evt", 32'(wall_evt), 1);
        check("t4_wall_no_eat", 32'(eat_evt), 0);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            pulses += int'(wall_evt);
        end
        check("t4_wall_held", 32'(pulses), 0);
        set_head(630, 100);
        step();
        check("t4_wall_630", 32'(wall_evt), 0);
        set_head(635, 100);
        step();
        check("t4_wall_635", 32'(wall_evt), 1);
        set_head(630, 100);
        set_tgt(0, 1020, 100);
        tgt_en = 4'b0001;
        step();
        check("t4_no_hit_630", 32'(eat_evt), 0);
        // Far edge: only 11-bit sums see this overlap and boundary crossing
        set_head(1023, 100);
        step();
        check("t4_1023_wall", 32'(wall_evt), 1);
        check("t4_1023_eat", 32'(eat_evt), 1);
        check("t4_1023_mask", 32'(eat_mask), 4'b0001);
        check("t4_1023_count", 32'(eat_count), 4);

        // Drive the counter to saturation
        set_tgt(0, 100, 100);
        for (int i = 0; i < 251; i++) begin
            set_head(200, 100);
            step();
            set_head(100, 100);
            step();
        end
        check("t5_count_255", 32'(eat_count), 255);
        set_head(200, 100);
        step();
        set_head(100, 100);
        step();
        check("t5_sat_evt", 32'(eat_evt), 1);
        check("t5_sat_count", 32'(eat_count), 255);

        // Reset wins over a simultaneous rising hit
        set_head(200, 100);
        step();
        set_head(100, 100);
        reset = 1'b1;
        step();
        check("t5_rst_evt", 32'(eat_evt), 0);
        check("t5_rst_count", 32'(eat_count), 0);
        check("t5_rst_armed", 32'(armed), 0);
        check("t5_rst_mask", 32'(eat_mask), 0);
        reset  = 1'b0;
        tgt_en = 4'b0000;
        tick   = 1'b1;
        step();
        tick = 1'b0;
        check("t6_rearmed", 32'(armed), 1);

        // Enabling a target that already overlaps is a rising edge
        set_tgt(2, 100, 100);
        step();
        step();
        check("t6_disabled_no_evt", 32'(eat_evt), 0);
        tgt_en = 4'b0100;
        step();
        check("t6_evt", 32'(eat_evt), 1);
        check("t6_idx", 32'(eat_idx), 2);
        check("t6_mask", 32'(eat_mask), 4'b0100);
        check("t6_count", 32'(eat_count), 1);
        step();
        check("t6_single_pulse", 32'(eat_evt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
